// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider.
//   div_state_t   : controller state encoding (IDLE, RUN)
//   DIV_WIDTH_DEF : default operand/result width
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/ready handshake and operand/result bus of seq_divider.
//   start       : request, taken on a rising edge while ready=1
//   dividend    : unsigned numerator, sampled with start
//   divisor     : unsigned denominator, sampled with start
//   quotient    : last result quotient
//   remainder   : last result remainder
//   ready       : idle, results valid, start accepted
//   done        : one-cycle pulse when new results land
//   div_by_zero : last accepted op had a zero divisor (DIV_ZERO_CHECK_EN builds)
// modport master drives the request side, modport slave is the divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             ready;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ready, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ready, done, div_by_zero
  );

endinterface

// File: rtl/div_controller.sv
// div_controller: IDLE/RUN FSM and iteration down-counter for seq_divider.
//   clk_in     : clock, rising edge
//   rst_in     : asynchronous active-low reset
//   i_start    : request from the handshake bus
//   i_div_zero : divisor of the request is zero (DIV_ZERO_CHECK_EN only)
//   o_load     : accept a normal request this edge (latch operands)
//   o_zero_op  : accept a zero-divisor request this edge (DIV_ZERO_CHECK_EN only)
//   o_step     : perform one restoring-division iteration this edge
//   o_finish   : last iteration this edge, results are committed
//   o_ready    : registered, high while idle
//   o_done     : registered, one-cycle pulse after results are written
// Optional feature macro: DIV_ZERO_CHECK_EN.
module div_controller
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_start,
`ifdef DIV_ZERO_CHECK_EN
  input  logic i_div_zero,
  output logic o_zero_op,
`endif
  output logic o_load,
  output logic o_step,
  output logic o_finish,
  output logic o_ready,
  output logic o_done
);

  localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  div_state_t    r_state;
  logic [CW-1:0] r_count;
  logic          r_ready;
  logic          r_done;
  logic          w_accept;

  assign w_accept = r_ready & i_start;

`ifdef DIV_ZERO_CHECK_EN
  assign o_zero_op = w_accept & i_div_zero;
  assign o_load    = w_accept & ~i_div_zero;
`else
  assign o_load    = w_accept;
`endif

  assign o_step   = (r_state == RUN);
  assign o_finish = o_step & (r_count == '0);
  assign o_ready  = r_ready;
  assign o_done   = r_done;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (o_load) begin
            r_state <= RUN;
            r_count <= CNT_LAST;
            r_ready <= 1'b0;
          end
`ifdef DIV_ZERO_CHECK_EN
          // Zero divisor is resolved in place: results land now, stay idle.
          else if (o_zero_op) begin
            r_done <= 1'b1;
          end
`endif
        end
        RUN: begin
          if (r_count == '0) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned sequential restoring divider, one quotient bit per clock.
//   clk_in : clock, rising edge
//   rst_in : asynchronous active-low reset
//   bus    : seq_divider_if.slave (start/dividend/divisor in,
//            quotient/remainder/ready/done/div_by_zero out)
// Latency: ready low for WIDTH cycles after the accepting edge; results and
// done appear together after the last iteration.
// Optional feature macro: DIV_ZERO_CHECK_EN (zero divisor answered in one
// edge without entering RUN, flagged on div_by_zero).
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic           clk_in,
  input  logic           rst_in,
  seq_divider_if.slave   bus
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_ready;
  logic             w_done;

`ifdef DIV_ZERO_CHECK_EN
  logic r_dbz;
  logic w_zero_op;
`endif

  div_controller #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_start    (bus.start),
`ifdef DIV_ZERO_CHECK_EN
    .i_div_zero (bus.divisor == '0),
    .o_zero_op  (w_zero_op),
`endif
    .o_load     (w_load),
    .o_step     (w_step),
    .o_finish   (w_finish),
    .o_ready    (w_ready),
    .o_done     (w_done)
  );

  // Trial subtract of the shifted partial remainder; the MSB is the borrow.
  // Dropping rem's MSB on the restore path is safe: the shifted value is
  // below the divisor there, so it fits in WIDTH bits.
  always_comb begin
    w_trial = {r_rem, r_q[WIDTH-1]} - {1'b0, r_div};
    if (!w_trial[WIDTH]) begin
      w_rem_nxt = w_trial[WIDTH-1:0];
      w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_nxt = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
      w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_quot <= '0;
      r_remd <= '0;
`ifdef DIV_ZERO_CHECK_EN
      r_dbz  <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_div <= bus.divisor;
        r_rem <= '0;
        r_q   <= bus.dividend;
      end else if (w_step) begin
        r_rem <= w_rem_nxt;
        r_q   <= w_q_nxt;
      end
      if (w_finish) begin
        r_quot <= w_q_nxt;
        r_remd <= w_rem_nxt;
`ifdef DIV_ZERO_CHECK_EN
        r_dbz  <= 1'b0;
`endif
      end
`ifdef DIV_ZERO_CHECK_EN
      if (w_zero_op) begin
        r_quot <= '1;
        r_remd <= bus.dividend;
        r_dbz  <= 1'b1;
      end
`endif
    end
  end

  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remd;
  assign bus.ready     = w_ready;
  assign bus.done      = w_done;
`ifdef DIV_ZERO_CHECK_EN
  assign bus.div_by_zero = r_dbz;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider. Stimulus pushes the
// arithmetic result and the cycle at which done must appear; a monitor pops
// on every done pulse and also checks that results hold during RUN.
module tb_seq_divider;
  import div_pkg::*;

  localparam int unsigned W    = DIV_WIDTH_DEF;
  localparam int unsigned MAXV = (1 << W) - 1;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  seq_divider_if #(.WIDTH(W)) u_if ();

  seq_divider #(.WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (u_if)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc++;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned z;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned last_q  = 0;
  int unsigned last_r  = 0;

  task automatic check(string name, int unsigned act, int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic, with the defined zero-divisor result.
  task automatic push(int unsigned a, int unsigned b, int unsigned e0);
    exp_t e;
    if (b == 0) begin
      e.q   = MAXV;
      e.r   = a;
      e.z   = ZCHK ? 1 : 0;
      e.due = ZCHK ? e0 : e0 + W;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.z   = 0;
      e.due = e0 + W;
    end
    sb.push_back(e);
  endtask

  // Monitor
  always @(negedge clk_in) begin
    if (!rst_in) begin
      last_q = 0;
      last_r = 0;
    end else begin
      if (u_if.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", u_if.quotient, e.q);
          check("remainder", u_if.remainder, e.r);
          check("div_by_zero", u_if.div_by_zero, e.z);
          check("done_cycle", cyc, e.due);
          check("ready_with_done", u_if.ready, 1);
          last_q = e.q;
          last_r = e.r;
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        check("done_missing", 0, 1);
        void'(sb.pop_front());
      end
      if (!u_if.ready) begin
        check("quot_stable", u_if.quotient, last_q);
        check("rem_stable", u_if.remainder, last_r);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!u_if.ready && k < 200) begin
      @(negedge clk_in);
      k++;
    end
    if (!u_if.ready) check("ready_timeout", 0, 1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(int unsigned a, int unsigned b);
    wait_ready();
    u_if.dividend = W'(a);
    u_if.divisor  = W'(b);
    u_if.start    = 1'b1;
    push(a, b, cyc + 1);
    @(negedge clk_in);
    u_if.start    = 1'b0;
    u_if.dividend = W'($urandom);
    u_if.divisor  = W'($urandom);
  endtask

  task automatic count_busy(string name, int unsigned exp);
    int unsigned n = 0;
    while (!u_if.ready && n < 100) begin
      n++;
      @(negedge clk_in);
    end
    check(name, n, exp);
  endtask

  task automatic check_reset_vals();
    check("rst_quotient", u_if.quotient, 0);
    check("rst_remainder", u_if.remainder, 0);
    check("rst_ready", u_if.ready, 1);
    check("rst_done", u_if.done, 0);
    check("rst_dbz", u_if.div_by_zero, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    u_if.start    = 1'b0;
    u_if.dividend = '0;
    u_if.divisor  = '0;
    repeat (3) @(negedge clk_in);
    check_reset_vals();
    rst_in = 1'b1;
    @(negedge clk_in);

    // 10/3 with busy-length check
    issue(10, 3);
    count_busy("busy_10_3", W);

    issue(15, 1);
    issue(7, 9);
    issue(15, 15);

    // zero divisor
    issue(10, 0);
    count_busy("busy_10_0", ZCHK ? 0 : W);

    // start held high across two ops
    wait_ready();
    u_if.start    = 1'b1;
    u_if.dividend = W'(12);
    u_if.divisor  = W'(5);
    e0 = cyc + 1;
    push(12, 5, e0);
    @(negedge clk_in);
    u_if.dividend = W'(9);
    u_if.divisor  = W'(2);
    push(9, 2, e0 + W + 1);
    repeat (W + 1) @(negedge clk_in);
    check("b2b_accept", u_if.ready, 0);
    u_if.start = 1'b0;

    // start pulse mid-RUN must be ignored
    issue(11, 3);
    @(negedge clk_in);
    u_if.start    = 1'b1;
    u_if.dividend = W'($urandom);
    u_if.divisor  = W'($urandom_range(0, 1));
    @(negedge clk_in);
    u_if.start = 1'b0;

    // reset during RUN
    issue(13, 4);
    @(negedge clk_in);
    rst_in = 1'b0;
    void'(sb.pop_back());
    #1;
    check_reset_vals();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    issue(13, 4);

    // exhaustive nonzero-divisor sweep
    for (int unsigned a = 0; a <= MAXV; a++)
      for (int unsigned b = 1; b <= MAXV; b++)
        issue(a, b);

    // random ops, zero divisor allowed, with random idle gaps
    for (int i = 0; i < 200; i++) begin
      issue($urandom_range(0, MAXV), $urandom_range(0, MAXV));
      if ($urandom_range(0, 3) == 0) begin
        wait_ready();
        repeat ($urandom_range(1, 3)) @(negedge clk_in);
      end
    end

    begin
      int k = 0;
      while (sb.size() > 0 && k < 200) begin
        @(negedge clk_in);
        k++;
      end
      if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    end
    repeat (2) @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
